text_letter_frontend: RTL

Upstream stage of the hyperdimensional language classifier. It accepts a raw ASCII byte stream for one text through a valid/ready handshake and maps each byte to a letter code. Letter codes are buffered in a small FIFO and presented to the HD encoder as letterReady/inputLetter beats. At end of text it drives the rst_RI and textDone sequencing that the encoder expects.

---
 rtl/text_letter_frontend.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/text_letter_frontend.sv
// text_letter_frontend
// Front end of the hyperdimensional language classifier. It takes raw ASCII
// bytes for one text, maps them to letter codes, and buffers the codes in a
// small FIFO. It presents them to the HD encoder one beat at a time, then
// sequences rst_RI/textDone at the end of the text.
module text_letter_frontend #(
  parameter int MAXLETTERS     = 27,
  parameter int FIFO_DEPTH     = 4,
  parameter bit FOLD_CASE      = 1'b1,
  parameter bit COLLAPSE_SPACE = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  input  logic             char_last,
  output logic             char_ready,
  input  logic             hd_ready,
  input  logic             next_text,
  output logic             letterReady,
  output logic [4:0]       inputLetter,
  output logic             textDone,
  output logic             rst_RI,
  output logic [CNT_W-1:0] unknown_count,
  output logic [CNT_W-1:0] letter_count,
  output logic             busy
);

  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam logic [4:0] SPACE_CODE = 5'(MAXLETTERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE,
    HOLD
  } state_t;

  state_t state;

  // FIFO storage and pointers; the extra pointer bit tells full from empty.
  logic [4:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;

  // Byte classification.
  logic       is_lower;
  logic       is_upper;
  logic       is_space;
  logic       is_known;
  logic       drop_space;
  logic [4:0] byte_code;
  logic       last_space;

  logic accept;
  logic push;
  logic pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Depends only on state and occupancy, never on char_valid, so the upstream
  // handshake carries no combinational loop. Held low while rst is asserted.
  assign char_ready = !rst && ((state == IDLE) || (state == STREAM)) && !fifo_full;
  assign accept     = char_valid && char_ready;

  assign is_lower   = (char_data >= 8'h61) && (char_data <= 8'h7a);
  assign is_upper   = FOLD_CASE && (char_data >= 8'h41) && (char_data <= 8'h5a);
  assign is_space   = (char_data == 8'h20);
  assign is_known   = is_lower || is_upper || is_space;
  // 'a' and 'A' both have 5'd1 in their low five bits, so one subtract maps both cases.
  assign byte_code  = is_space ? SPACE_CODE : (char_data[4:0] - 5'd1);
  assign drop_space = COLLAPSE_SPACE && is_space && last_space;

  assign push = accept && is_known && !drop_space;
  assign pop  = !fifo_empty && hd_ready && ((state == STREAM) || (state == DRAIN));

  assign busy = (state != IDLE);

  // FIFO storage write port.
  // NOTE: the storage array has no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= byte_code;
    end
  end

  // FIFO pointer bookkeeping.
  // NOTE: every sequential block uses non-blocking assignments so that all
  // registers update from the values before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Output stage: the popped head becomes a registered beat for the encoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      letterReady <= 1'b0;
      inputLetter <= '0;
    end else begin
      letterReady <= pop;
      if (pop) inputLetter <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Text sequencing FSM with registered rst_RI/textDone, counters and space tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rst_RI        <= 1'b0;
      textDone      <= 1'b0;
      unknown_count <= '0;
      letter_count  <= '0;
      last_space    <= 1'b0;
    end else begin
      textDone <= 1'b0;

      if (accept && !is_known && (unknown_count != '1)) begin
        unknown_count <= unknown_count + CNT_W'(1);
      end
      if (pop && (letter_count != '1)) begin
        letter_count <= letter_count + CNT_W'(1);
      end
      if (push) begin
        last_space <= is_space;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            rst_RI <= 1'b1;
            state  <= char_last ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (accept && char_last) state <= DRAIN;
        end
        DRAIN: begin
          // Wait until the last beat has been presented before signalling done.
          if (fifo_empty && !letterReady) begin
            state    <= DONE;
            textDone <= 1'b1;
          end
        end
        DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          if (next_text) begin
            state         <= IDLE;
            rst_RI        <= 1'b0;
            unknown_count <= '0;
            letter_count  <= '0;
            last_space    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
